wb_write_port: RTL and testbench
================================

# wb_write_port

Writeback-side write port controller for the 16 x 16-bit register file, the write-direction counterpart of the register file's read wordline decoding. Accepts writeback requests (register ID + data) through a valid/ready handshake and buffers them in a 2-entry in-order queue. Drives one one-hot write wordline per granted cycle. Exposes pending-write bypass data to the two decode-stage read ports. Sits between the writeback stage and the register file write side; R0 is hardwired zero.

## Interface
- DEPTH, 2, queue entries (fixed at 2; count width 2 bits)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wb_valid  in  1  writeback request valid
- wb_ready  out  1  request can be accepted this cycle
- wb_reg  in  4  destination register ID
- wb_data  in  16  write data
- rf_wr_grant  in  1  register file write side available this cycle
- wr_wordline  out  16  one-hot write enable to register file; all-zero when no write
- wr_data  out  16  data for the asserted wordline
- src1_reg, src2_reg  in  4 each  read-port register IDs
- src1_hit, src2_hit  out  1 each  a queued write to that register exists
- src1_data, src2_data  out  16 each  data of youngest matching queued entry; 0 when no hit
- pending  out  16  bitmap of registers with a queued write
- count  out  2  number of valid queue entries (0..2)

## Operation
- Accept: wb_valid && wb_ready at a rising edge.
- wb_ready = !rst && (count < 2). It has no combinational dependence on rf_wr_grant.
- Accepted request with wb_reg == 0: dropped. It is consumed but never queued, never written, never bypassed, and count is unchanged.
- Queue: circular 2-entry buffer with head/tail pointers wrapping 1 -> 0. Strict FIFO order; no coalescing of same-register entries.
- Drain: when count > 0 and rf_wr_grant = 1:
  - wr_wordline = one-hot(head.reg), i.e. bit k set iff head.reg == k.
  - wr_data = head.data.
  - The register file captures the write at the next edge; the head pops at that same edge.
- Otherwise wr_wordline = 16'h0000 and wr_data = 16'h0000.
- Simultaneous accept + pop: legal only at count = 1. Count stays 1 and the new entry becomes head.
- Bypass, per port independently:
  - hit = 1 iff src_reg != 0 and some valid entry has matching reg.
  - If both entries match, the tail (younger) entry's data wins.
  - The entry being drained this cycle still counts as a hit.
- pending = OR of one-hot(reg) over valid entries.
- Reset, including mid-operation: count = 0 and pointers = 0. Queued entries are discarded without being written.

## Timing
- Reset values (while rst high and the cycle after with no accept):
  - wb_ready = 0 during rst, 1 after.
  - wr_wordline = 0, wr_data = 0, pending = 0, count = 0.
  - src*_hit = 0, src*_data = 0.
- Accept at edge N: the entry is visible to count, pending and bypass from cycle N+1.
- Earliest write: wr_wordline is asserted in cycle N+1 if grant = 1, and the register file commits at edge N+2. This gives 1-cycle latency from accept to wordline.
- Throughput: 1 write per cycle with grant held high and wb_valid continuous; wb_ready never drops.
- Grant low: the queue holds. After 2 accepts wb_ready falls the cycle after the second accept and recovers the cycle after the first pop.
- wr_wordline is never multi-hot; it is zero whenever count = 0, regardless of grant.
- Bypass outputs are combinational from src*_reg and queue state; there is no added latency.

## Test plan
- Reset, then accept R5 = 0xBEEF with grant = 1:
  - Next cycle: wr_wordline = 0x0020, wr_data = 0xBEEF, pending = 0x0020, count = 1.
  - Cycle after: all zero.
- Grant = 0; accept R3 = 0x1111 then R3 = 0x2222:
  - count = 2, wb_ready = 0.
  - src1_reg = 3 gives hit = 1, data = 0x2222.
  - Raise grant: wordline 0x0008 with 0x1111, then 0x0008 with 0x2222 on consecutive cycles, then count = 0.
- Accept R0 = 0xFFFF:
  - count stays 0, wr_wordline stays 0, pending = 0.
  - src2_reg = 0 gives hit = 0.
- count = 1 (R7 = 0x00AA), grant = 1, same-cycle accept of R9 = 0x0055:
  - Wordline 0x0080 / 0x00AA this cycle.
  - Next cycle: 0x0200 / 0x0055, count = 1.
- Two entries queued with grant = 0, assert rst for one cycle:
  - Afterwards count = 0, pending = 0, no wordline ever asserts for the discarded entries, and wb_ready = 1.
- Sweep accepts R1..R15 with grant = 1:
  - Each wordline equals 1 << reg exactly one cycle after accept.
  - wr_data matches each request, and no beat is lost or duplicated.

Source files
------------

// File: rtl/wb_write_port.sv
// Writeback write port: 2-entry in-order queue of (reg, data) writes that drains
// into the register file one-hot wordline, with pending-write bypass for two read ports.
module wb_write_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [3:0]  wb_reg,
  input  logic [15:0] wb_data,
  input  logic        rf_wr_grant,
  output logic [15:0] wr_wordline,
  output logic [15:0] wr_data,
  input  logic [3:0]  src1_reg,
  input  logic [3:0]  src2_reg,
  output logic        src1_hit,
  output logic        src2_hit,
  output logic [15:0] src1_data,
  output logic [15:0] src2_data,
  output logic [15:0] pending,
  output logic [1:0]  count
);

  logic [3:0]  ent_reg  [2];
  logic [15:0] ent_data [2];
  logic        head_ptr;
  logic        tail_ptr;
  logic [1:0]  count_q;
  logic [1:0]  ent_valid;
  logic        accept;
  logic        push;
  logic        pop;

  assign wb_ready = !rst && (count_q != 2'd2);
  assign accept   = wb_valid && wb_ready;
  // R0 is hardwired zero, so writes to it are consumed and dropped here.
  assign push     = accept && (wb_reg != 4'd0);
  assign pop      = (count_q != 2'd0) && rf_wr_grant;
  assign count    = count_q;

  always_comb begin
    ent_valid = 2'b00;
    if (count_q == 2'd2) begin
      ent_valid = 2'b11;
    end else if (count_q == 2'd1) begin
      ent_valid[head_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        ent_reg[tail_ptr]  <= wb_reg;
        ent_data[tail_ptr] <= wb_data;
        tail_ptr           <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    wr_wordline = 16'h0000;
    wr_data     = 16'h0000;
    if (pop) begin
      wr_wordline = 16'h0001 << ent_reg[head_ptr];
      wr_data     = ent_data[head_ptr];
    end
  end

  always_comb begin
    pending = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      if (ent_valid[i]) begin
        pending = pending | (16'h0001 << ent_reg[i]);
      end
    end
  end

  // The non-head slot is only valid when both are full, and then it is the younger one.
  function automatic logic [16:0] lookup(
    input logic [3:0]  src,
    input logic [1:0]  vld,
    input logic        hd,
    input logic [3:0]  r0,
    input logic [3:0]  r1,
    input logic [15:0] d0,
    input logic [15:0] d1
  );
    logic [1:0]  m;
    logic [16:0] res;
    m[0] = vld[0] && (r0 == src) && (src != 4'd0);
    m[1] = vld[1] && (r1 == src) && (src != 4'd0);
    res  = 17'd0;
    if (m[~hd]) begin
      res = {1'b1, (~hd) ? d1 : d0};
    end else if (m[hd]) begin
      res = {1'b1, hd ? d1 : d0};
    end
    return res;
  endfunction

  always_comb begin
    {src1_hit, src1_data} = lookup(src1_reg, ent_valid, head_ptr,
                                   ent_reg[0], ent_reg[1], ent_data[0], ent_data[1]);
    {src2_hit, src2_data} = lookup(src2_reg, ent_valid, head_ptr,
                                   ent_reg[0], ent_reg[1], ent_data[0], ent_data[1]);
  end

endmodule

// File: tb/tb_wb_write_port.sv
// Directed bench for wb_write_port: per-cycle vector table plus a back-to-back sweep.
module tb_wb_write_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_reg;
  logic [15:0] wb_data;
  logic        rf_wr_grant;
  logic [15:0] wr_wordline;
  logic [15:0] wr_data;
  logic [3:0]  src1_reg;
  logic [3:0]  src2_reg;
  logic        src1_hit;
  logic        src2_hit;
  logic [15:0] src1_data;
  logic [15:0] src2_data;
  logic [15:0] pending;
  logic [1:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_write_port dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_reg(wb_reg), .wb_data(wb_data), .rf_wr_grant(rf_wr_grant),
    .wr_wordline(wr_wordline), .wr_data(wr_data),
    .src1_reg(src1_reg), .src2_reg(src2_reg),
    .src1_hit(src1_hit), .src2_hit(src2_hit),
    .src1_data(src1_data), .src2_data(src2_data),
    .pending(pending), .count(count)
  );

  typedef struct {
    logic        rst;
    logic        vld;
    logic [3:0]  wreg;
    logic [15:0] wdat;
    logic        gnt;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic        rdy;
    logic [15:0] wl;
    logic [15:0] wd;
    logic        h1;
    logic [15:0] d1;
    logic        h2;
    logic [15:0] d2;
    logic [15:0] pend;
    logic [1:0]  cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic v, input logic [3:0] wr, input logic [15:0] wdt,
    input logic g, input logic [3:0] a, input logic [3:0] b,
    input logic rdy, input logic [15:0] wl, input logic [15:0] wd,
    input logic h1, input logic [15:0] d1, input logic h2, input logic [15:0] d2,
    input logic [15:0] pend, input logic [1:0] cnt);
    vec_t t;
    t.rst = r; t.vld = v; t.wreg = wr; t.wdat = wdt; t.gnt = g; t.s1 = a; t.s2 = b;
    t.rdy = rdy; t.wl = wl; t.wd = wd; t.h1 = h1; t.d1 = d1; t.h2 = h2; t.d2 = d2;
    t.pend = pend; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic invariants(input string tag);
    chk({tag, "_onehot"}, 32'($countones(wr_wordline) <= 1), 32'd1);
    chk({tag, "_idle_wl"}, 32'((count == 2'd0) && (wr_wordline != 16'h0000)), 32'd0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    @(negedge clk);
    rst = v.rst; wb_valid = v.vld; wb_reg = v.wreg; wb_data = v.wdat;
    rf_wr_grant = v.gnt; src1_reg = v.s1; src2_reg = v.s2;
    #1;
    chk({t, "_ready"},    32'(wb_ready),    32'(v.rdy));
    chk({t, "_wordline"}, 32'(wr_wordline), 32'(v.wl));
    chk({t, "_wr_data"},  32'(wr_data),     32'(v.wd));
    chk({t, "_hit1"},     32'(src1_hit),    32'(v.h1));
    chk({t, "_data1"},    32'(src1_data),   32'(v.d1));
    chk({t, "_hit2"},     32'(src2_hit),    32'(v.h2));
    chk({t, "_data2"},    32'(src2_data),   32'(v.d2));
    chk({t, "_pending"},  32'(pending),     32'(v.pend));
    chk({t, "_count"},    32'(count),       32'(v.cnt));
    invariants(t);
  endtask

  vec_t vecs [22];

  initial begin
    // rst vld reg data gnt s1 s2 | rdy wl wd h1 d1 h2 d2 pend cnt
    vecs[0]  = mk(1,0,0,16'h0000,0,0,0, 0,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[1]  = mk(0,0,0,16'h0000,0,0,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[2]  = mk(0,1,5,16'hBEEF,1,5,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[3]  = mk(0,0,0,16'h0000,1,5,0, 1,16'h0020,16'hBEEF,1,16'hBEEF,0,16'h0000,16'h0020,1);
    vecs[4]  = mk(0,0,0,16'h0000,1,5,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[5]  = mk(0,1,3,16'h1111,0,0,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[6]  = mk(0,1,3,16'h2222,0,3,0, 1,16'h0000,16'h0000,1,16'h1111,0,16'h0000,16'h0008,1);
    vecs[7]  = mk(0,1,6,16'h6666,0,3,3, 0,16'h0000,16'h0000,1,16'h2222,1,16'h2222,16'h0008,2);
    vecs[8]  = mk(0,0,0,16'h0000,1,3,4, 0,16'h0008,16'h1111,1,16'h2222,0,16'h0000,16'h0008,2);
    vecs[9]  = mk(0,0,0,16'h0000,1,3,0, 1,16'h0008,16'h2222,1,16'h2222,0,16'h0000,16'h0008,1);
    vecs[10] = mk(0,0,0,16'h0000,1,3,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[11] = mk(0,1,0,16'hFFFF,1,0,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[12] = mk(0,0,0,16'h0000,1,0,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[13] = mk(0,1,7,16'h00AA,0,0,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[14] = mk(0,1,9,16'h0055,1,7,0, 1,16'h0080,16'h00AA,1,16'h00AA,0,16'h0000,16'h0080,1);
    vecs[15] = mk(0,0,0,16'h0000,1,9,7, 1,16'h0200,16'h0055,1,16'h0055,0,16'h0000,16'h0200,1);
    vecs[16] = mk(0,0,0,16'h0000,0,9,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[17] = mk(0,1,2,16'h1234,0,2,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[18] = mk(0,1,4,16'h5678,0,2,4, 1,16'h0000,16'h0000,1,16'h1234,0,16'h0000,16'h0004,1);
    vecs[19] = mk(1,0,0,16'h0000,0,2,4, 0,16'h0000,16'h0000,1,16'h1234,1,16'h5678,16'h0014,2);
    vecs[20] = mk(0,0,0,16'h0000,1,2,4, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);
    vecs[21] = mk(0,0,0,16'h0000,1,0,0, 1,16'h0000,16'h0000,0,16'h0000,0,16'h0000,16'h0000,0);

    rst = 1'b1; wb_valid = 1'b0; wb_reg = 4'd0; wb_data = 16'h0000;
    rf_wr_grant = 1'b0; src1_reg = 4'd0; src2_reg = 4'd0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 22; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-to-back accepts with grant held: each beat drains the cycle after accept.
    for (int r = 1; r < 16; r++) begin
      @(negedge clk);
      wb_valid = 1'b1; wb_reg = 4'(r); wb_data = 16'hA000 | 16'(r);
      rf_wr_grant = 1'b1; src1_reg = 4'd0; src2_reg = 4'd0;
      #1;
      chk($sformatf("sweep%0d_ready", r), 32'(wb_ready), 32'd1);
      if (r == 1) begin
        chk("sweep1_wordline", 32'(wr_wordline), 32'd0);
        chk("sweep1_count", 32'(count), 32'd0);
      end else begin
        chk($sformatf("sweep%0d_wordline", r), 32'(wr_wordline), 32'(16'h0001 << (r - 1)));
        chk($sformatf("sweep%0d_wr_data", r), 32'(wr_data), 32'(16'hA000 | 16'(r - 1)));
        chk($sformatf("sweep%0d_count", r), 32'(count), 32'd1);
      end
      invariants($sformatf("sweep%0d", r));
    end
    @(negedge clk);
    wb_valid = 1'b0;
    #1;
    chk("sweep_last_wordline", 32'(wr_wordline), 32'h8000);
    chk("sweep_last_wr_data", 32'(wr_data), 32'hA00F);
    @(negedge clk);
    #1;
    chk("sweep_end_count", 32'(count), 32'd0);
    chk("sweep_end_wordline", 32'(wr_wordline), 32'd0);
    chk("sweep_end_pending", 32'(pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
